nn_argmax: RTL and testbench
============================

NN_ARGMAX -- requirements
Module: nn_argmax

Interface
REQ-001 Parameter OUTPUT_SIZE, default 5: number of output-layer scores per classification; legal range 1..16.
REQ-002 Parameter WIDTH, default 16: bit width of each score, two's-complement signed.
REQ-003 Parameter IDX_W, default 3: class index width, SHALL equal max(1, clog2(OUTPUT_SIZE)).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  score vector on `scores` is valid.
REQ-007 in_ready  output  1  block can accept a score vector.
REQ-008 scores  input  OUTPUT_SIZE*WIDTH  packed score vector; score k occupies bits [k*WIDTH +: WIDTH].
REQ-009 out_valid  output  1  classification result valid.
REQ-010 out_ready  input  1  downstream accepts result.
REQ-011 class_idx  output  IDX_W  index of the maximum score.
REQ-012 max_score  output  WIDTH  value of the maximum score.

Function
REQ-013 FSM states SHALL be IDLE, SCAN, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Accept occurs on a rising edge with IDLE and in_valid=1: the full `scores` vector is captured into an internal register, best value is loaded with score 0, best index with 0, scan counter with 1.
REQ-016 On accept, next state SHALL be SCAN if OUTPUT_SIZE>1, else DONE.
REQ-017 In SCAN, each edge SHALL compare captured score[cnt] against the best value as signed numbers; strictly greater replaces best value and best index with score[cnt] and cnt.
REQ-018 Ties SHALL keep the existing best, so the lowest index among equal maxima wins.
REQ-019 In SCAN, the edge processing cnt=OUTPUT_SIZE-1 SHALL move to DONE; otherwise cnt increments by 1.
REQ-020 Latency: out_valid SHALL rise exactly OUTPUT_SIZE-1 edges after the accept edge (4 for default; 0 extra edges when OUTPUT_SIZE=1, i.e. valid after accept edge).
REQ-021 class_idx and max_score SHALL be driven from the best registers and remain stable throughout DONE.
REQ-022 In DONE, out_valid SHALL stay 1 until out_ready=1 on an edge; that edge returns to IDLE.
REQ-023 No back-to-back bypass: a new vector is accepted no earlier than the edge after the result handshake.
REQ-024 Changes on `scores` or in_valid outside an accept edge SHALL have no effect on the result in progress.
REQ-025 out_ready while not in DONE SHALL be ignored.
REQ-026 Comparison SHALL be full WIDTH signed with no saturation or truncation; most-negative value is legal.

Reset
REQ-027 rst_n=0 SHALL immediately, independent of clk, force state IDLE, cnt=0, best value=0, best index=0, captured scores=0.
REQ-028 During and immediately after reset: in_ready=1, out_valid=0, class_idx=0, max_score=0.
REQ-029 Reset asserted in SCAN or DONE SHALL abort the operation; the pending result is discarded and never presented.
REQ-030 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-031 Default params, scores {10,-3,42,7,0} (k=0..4), out_ready=1 -> out_valid exactly 4 edges after accept, class_idx=2, max_score=42, back to IDLE next edge.
REQ-032 Ties: scores {5,9,9,-1,9} -> class_idx=1, max_score=9.
REQ-033 All negative: scores {-32768,-2,-5,-2,-32767} -> class_idx=1, max_score=-2 (0xFFFE).
REQ-034 Backpressure: out_ready=0 for 10 cycles after out_valid -> outputs stable, in_ready=0, a toggling in_valid/scores not captured; result accepted when out_ready=1.
REQ-035 Reset mid-SCAN (2 edges after accept) -> out_valid=0, in_ready=1 asynchronously; next vector {1,2,3,4,5} yields class_idx=4, max_score=5 with normal latency.
REQ-036 OUTPUT_SIZE=1, WIDTH=8, score {-7} -> out_valid the edge after accept, class_idx=0, max_score=-7.

Source files
------------

// File: rtl/nn_argmax_if.sv
// Handshake bundle for nn_argmax: score vector in, winning class and score out.
interface nn_argmax_if #(
  parameter int OUTPUT_SIZE = 5,
  parameter int WIDTH       = 16,
  parameter int IDX_W       = 3
);
  logic                         in_valid;
  logic                         in_ready;
  logic [OUTPUT_SIZE*WIDTH-1:0] scores;
  logic                         out_valid;
  logic                         out_ready;
  logic [IDX_W-1:0]             class_idx;
  logic [WIDTH-1:0]             max_score;

  modport master (
    output in_valid, scores, out_ready,
    input  in_ready, out_valid, class_idx, max_score
  );

  modport slave (
    input  in_valid, scores, out_ready,
    output in_ready, out_valid, class_idx, max_score
  );
endinterface

// File: rtl/nn_argmax.sv
// Sequential argmax over a captured vector of signed scores, one comparison per clock.
// Ties keep the earlier index, so the lowest index among equal maxima wins.
module nn_argmax #(
  parameter int OUTPUT_SIZE = 5,
  parameter int WIDTH       = 16,
  parameter int IDX_W       = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  nn_argmax_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]                   state_q, state_d;
  logic [IDX_W-1:0]             cnt_q, cnt_d;
  logic [IDX_W-1:0]             best_idx_q, best_idx_d;
  logic signed [WIDTH-1:0]      best_val_q, best_val_d;
  logic [OUTPUT_SIZE*WIDTH-1:0] cap_q, cap_d;
  logic signed [WIDTH-1:0]      cur_score;

  // Mux the captured score selected by cnt; avoids an out-of-range array index.
  always_comb begin
    cur_score = '0;
    for (int k = 0; k < OUTPUT_SIZE; k++) begin
      if (cnt_q == IDX_W'(k)) begin
        cur_score = cap_q[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    cap_d      = cap_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          cap_d      = bus.scores;
          best_val_d = bus.scores[WIDTH-1:0];
          best_idx_d = '0;
          cnt_d      = IDX_W'(1);
          state_d    = (OUTPUT_SIZE > 1) ? SCAN : DONE;
        end
      end
      SCAN: begin
        if (cur_score > best_val_q) begin
          best_val_d = cur_score;
          best_idx_d = cnt_q;
        end
        if (cnt_q == IDX_W'(OUTPUT_SIZE - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      cap_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      cap_q      <= cap_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.class_idx = best_idx_q;
  assign bus.max_score = best_val_q;
endmodule

// File: tb/tb_nn_argmax.sv
// Self-checking bench for nn_argmax: directed and random vectors against an argmax model,
// backpressure, mid-scan reset, and a single-score 8-bit instance.
module tb_nn_argmax;
  logic clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;
  int vec [5];

  nn_argmax_if #(.OUTPUT_SIZE(5), .WIDTH(16), .IDX_W(3)) bus0 ();
  nn_argmax_if #(.OUTPUT_SIZE(1), .WIDTH(8),  .IDX_W(1)) bus1 ();

  nn_argmax #(.OUTPUT_SIZE(5), .WIDTH(16), .IDX_W(3)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  nn_argmax #(.OUTPUT_SIZE(1), .WIDTH(8), .IDX_W(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: largest value first, then the first position holding it.
  function automatic int model_max();
    int m = vec[0];
    foreach (vec[k]) if (vec[k] > m) m = vec[k];
    return m;
  endfunction

  function automatic int model_idx(input int m);
    for (int k = 0; k < 5; k++) if (vec[k] == m) return k;
    return -1;
  endfunction

  task automatic pack0();
    logic [79:0] p;
    for (int k = 0; k < 5; k++) p[k*16 +: 16] = vec[k][15:0];
    bus0.scores = p;
  endtask

  task automatic scramble0();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    bus0.scores   = r[79:0];
    bus0.in_valid = 1'($urandom_range(0, 1));
  endtask

  task automatic run0(input string tag, input int hold);
    int          m;
    int          idx;
    int          lat;
    logic [15:0] m16;
    m   = model_max();
    idx = model_idx(m);
    m16 = m[15:0];
    pack0();
    bus0.in_valid  = 1'b1;
    bus0.out_ready = 1'($urandom_range(0, 1));
    chk({tag, ".in_ready_idle"}, 32'(bus0.in_ready), 32'd1);
    tick();
    bus0.in_valid = 1'b0;
    lat = 0;
    while (bus0.out_valid !== 1'b1 && lat < 40) begin
      scramble0();
      bus0.out_ready = 1'($urandom_range(0, 1));
      tick();
      lat++;
    end
    bus0.in_valid = 1'b0;
    chk({tag, ".latency"}, 32'(lat), 32'd4);
    chk({tag, ".class_idx"}, 32'(bus0.class_idx), 32'(idx));
    chk({tag, ".max_score"}, 32'(bus0.max_score), 32'(m16));
    if (hold > 0) begin
      bus0.out_ready = 1'b0;
      for (int c = 0; c < hold; c++) begin
        scramble0();
        tick();
        chk({tag, ".hold_valid"}, 32'(bus0.out_valid), 32'd1);
        chk({tag, ".hold_ready"}, 32'(bus0.in_ready), 32'd0);
        chk({tag, ".hold_idx"}, 32'(bus0.class_idx), 32'(idx));
        chk({tag, ".hold_max"}, 32'(bus0.max_score), 32'(m16));
      end
      bus0.in_valid = 1'b0;
    end
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;
    chk({tag, ".post_valid"}, 32'(bus0.out_valid), 32'd0);
    chk({tag, ".post_ready"}, 32'(bus0.in_ready), 32'd1);
  endtask

  task automatic run1(input string tag, input int v);
    logic [7:0] v8;
    v8 = v[7:0];
    bus1.scores   = v8;
    bus1.in_valid = 1'b1;
    chk({tag, ".in_ready"}, 32'(bus1.in_ready), 32'd1);
    tick();
    bus1.in_valid = 1'b0;
    chk({tag, ".valid_next"}, 32'(bus1.out_valid), 32'd1);
    chk({tag, ".class_idx"}, 32'(bus1.class_idx), 32'd0);
    chk({tag, ".max_score"}, 32'(bus1.max_score), 32'(v8));
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
    chk({tag, ".post_valid"}, 32'(bus1.out_valid), 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus0.in_valid  = 1'b0;
    bus0.out_ready = 1'b0;
    bus0.scores    = '0;
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b0;
    bus1.scores    = '0;
    #3;
    chk("reset.in_ready",  32'(bus0.in_ready),  32'd1);
    chk("reset.out_valid", 32'(bus0.out_valid), 32'd0);
    chk("reset.class_idx", 32'(bus0.class_idx), 32'd0);
    chk("reset.max_score", 32'(bus0.max_score), 32'd0);
    chk("reset1.out_valid", 32'(bus1.out_valid), 32'd0);
    chk("reset1.in_ready",  32'(bus1.in_ready),  32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First accept lands on the first edge after reset release.
    vec = '{10, -3, 42, 7, 0};
    run0("basic", 0);
    vec = '{5, 9, 9, -1, 9};
    run0("ties", 0);
    vec = '{-32768, -2, -5, -2, -32767};
    run0("negative", 0);
    vec = '{-1, 3, -8, 3, 2};
    run0("backpressure", 10);

    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < 5; k++) begin
        case (t % 3)
          0:       vec[k] = int'($urandom_range(0, 65535)) - 32768;
          1:       vec[k] = int'($urandom_range(0, 2)) - 1;
          default: vec[k] = ($urandom_range(0, 1) != 0) ? -32768 : 32767;
        endcase
      end
      run0($sformatf("rand%0d", t), int'($urandom_range(0, 3)));
    end

    // Abort a scan two edges after accept; the pending result must vanish.
    vec = '{100, 200, 300, 400, 500};
    pack0();
    bus0.in_valid = 1'b1;
    tick();
    bus0.in_valid = 1'b0;
    tick();
    tick();
    chk("midscan.in_ready", 32'(bus0.in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort.out_valid", 32'(bus0.out_valid), 32'd0);
    chk("abort.in_ready",  32'(bus0.in_ready),  32'd1);
    chk("abort.class_idx", 32'(bus0.class_idx), 32'd0);
    chk("abort.max_score", 32'(bus0.max_score), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vec = '{1, 2, 3, 4, 5};
    run0("after_reset", 0);

    run1("single_m7", -7);
    run1("single_min", -128);
    run1("single_max", 127);
    run1("single_rand", int'($urandom_range(0, 255)) - 128);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
